// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcode, PC-control and state encodings for the decode stage
package decode_pkg;

   localparam int IW = 10;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_BEQZ = 4'b1100;
   localparam logic [3:0] OP_JR   = 4'b1101;
   localparam logic [3:0] OP_J    = 4'b1110;
   localparam logic [3:0] OP_HALT = 4'b1111;

   localparam logic [1:0] PC_INC    = 2'b00;
   localparam logic [1:0] PC_JUMP   = 2'b01;
   localparam logic [1:0] PC_REG    = 2'b10;
   localparam logic [1:0] PC_BRANCH = 2'b11;

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_SQUASH = 2'd1,
      S_HALT   = 2'd2
   } state_t;

   function automatic logic [3:0] opcode_of(input logic [IW-1:0] word);
      return word[IW-1:IW-4];
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID instruction register and valid flag
module if_id_reg #(
   parameter int            IW       = 10,
   parameter logic [IW-1:0] NOP_WORD = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          squash,
   input  logic [IW-1:0] instr_d,
   output logic [IW-1:0] ir,
   output logic          v
);

   // Capture the fetched word when enabled; a squashed load marks it invalid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ir <= NOP_WORD;
         v  <= 1'b0;
      end else if (load) begin
         ir <= instr_d;
         v  <= ~squash;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - IF/ID stage: control-flow decode and fetch PC control
module decode_stage
   import decode_pkg::*;
#(
   parameter int            IW       = 10,
   parameter logic [IW-1:0] NOP_WORD = 10'b0000000000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [IW-1:0] instruction,
   input  logic          stall,
   output logic [1:0]    reg_raddr,
   input  logic [IW-1:0] reg_rdata,
   output logic [1:0]    pc_control,
   output logic [IW-1:0] branch_control,
   output logic [4:0]    jump_address,
   output logic [2:0]    branch_address,
   output logic [IW-1:0] reg_address,
   output logic [IW-1:0] id_instr,
   output logic          id_valid,
   output logic          halted
);

   state_t        state, state_next;
   logic [IW-1:0] ir;
   logic          v;
   logic [3:0]    op;
   logic          redirect;
   logic          halt_op;
   logic          load;
   logic          squash;

   assign op        = opcode_of(ir);
   assign reg_raddr = ir[5:4];
   assign id_instr  = ir;

   // The wrong-path word behind a redirect, the bubble leaving SQUASH and the
   // word behind a HALT all enter the register marked invalid
   assign halt_op = v && (op == OP_HALT) && (state != S_HALT);
   assign load    = (state != S_HALT) && !stall;
   assign squash  = (state != S_RUN) || redirect || halt_op;

   if_id_reg #(
      .IW       (IW),
      .NOP_WORD (NOP_WORD)
   ) u_if_id_reg (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .squash  (squash),
      .instr_d (instruction),
      .ir      (ir),
      .v       (v)
   );

   // State register: RUN / SQUASH / HALT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_RUN;
      else       state <= state_next;
   end

   // Output decode with priority HALT > stall > redirect > default, plus next state
   always_comb begin
      pc_control     = PC_INC;
      branch_control = {IW{1'b1}};
      jump_address   = ir[4:0];
      branch_address = ir[2:0];
      reg_address    = reg_rdata;
      id_valid       = v;
      halted         = 1'b0;
      redirect       = 1'b0;
      state_next     = state;

      if (state == S_HALT) begin
         pc_control   = PC_JUMP;
         jump_address = 5'd0;
         id_valid     = 1'b0;
         halted       = 1'b1;
      end else if (stall) begin
         pc_control   = PC_JUMP;
         jump_address = 5'd0;
      end else begin
         if (v) begin
            case (op)
               OP_J: begin
                  pc_control = PC_JUMP;
                  redirect   = 1'b1;
               end
               OP_JR: begin
                  pc_control = PC_REG;
                  redirect   = 1'b1;
               end
               OP_BEQZ: begin
                  pc_control     = PC_BRANCH;
                  branch_control = reg_rdata;
                  redirect       = (reg_rdata == '0);
               end
               default: pc_control = PC_INC;
            endcase
         end

         if (halt_op)       state_next = S_HALT;
         else if (redirect) state_next = S_SQUASH;
         else               state_next = S_RUN;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed scoreboard bench for decode_stage
module tb_decode_stage;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] instruction;
   logic       stall;
   logic [1:0] reg_raddr;
   logic [9:0] reg_rdata;
   logic [1:0] pc_control;
   logic [9:0] branch_control;
   logic [4:0] jump_address;
   logic [2:0] branch_address;
   logic [9:0] reg_address;
   logic [9:0] id_instr;
   logic       id_valid;
   logic       halted;

   logic [9:0] rf [0:3];
   assign reg_rdata = rf[reg_raddr];

   always #5 clk = ~clk;

   decode_stage dut (
      .clk            (clk),
      .reset          (reset),
      .instruction    (instruction),
      .stall          (stall),
      .reg_raddr      (reg_raddr),
      .reg_rdata      (reg_rdata),
      .pc_control     (pc_control),
      .branch_control (branch_control),
      .jump_address   (jump_address),
      .branch_address (branch_address),
      .reg_address    (reg_address),
      .id_instr       (id_instr),
      .id_valid       (id_valid),
      .halted         (halted)
   );

   localparam logic [9:0] NOP  = 10'b0000000000;
   localparam logic [9:0] J    = 10'b1110011110;
   localparam logic [9:0] BEQZ = 10'b1100010010;
   localparam logic [9:0] JR   = 10'b1101100000;
   localparam logic [9:0] HALT = 10'b1111000000;
   localparam logic [9:0] ADD  = 10'b0101010101;

   typedef struct {
      string      tag;
      logic [1:0] pc;
      logic [4:0] ja;
      logic [9:0] bc;
      logic [2:0] ba;
      logic [9:0] ra;
      logic [9:0] instr;
      logic [1:0] raddr;
      logic       valid;
      logic       halted;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   function automatic exp_t base(input string tag, input logic [9:0] ir, input logic vld);
      exp_t e;
      e.tag    = tag;
      e.pc     = 2'b00;
      e.ja     = ir[4:0];
      e.bc     = 10'h3FF;
      e.ba     = ir[2:0];
      e.ra     = rf[ir[5:4]];
      e.instr  = ir;
      e.raddr  = ir[5:4];
      e.valid  = vld;
      e.halted = 1'b0;
      return e;
   endfunction

   task automatic chk(input string tag, input string name, input logic [9:0] got, input logic [9:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s %s: observed %0h expected %0h", tag, name, got, exp);
      end
   endtask

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         n_assert++;
         n_fail++;
         $error("FAIL scoreboard: observed empty queue expected entry");
      end else begin
         e = sb.pop_front();
         chk(e.tag, "pc_control",     {8'd0, pc_control},     {8'd0, e.pc});
         chk(e.tag, "jump_address",   {5'd0, jump_address},   {5'd0, e.ja});
         chk(e.tag, "branch_control", branch_control,         e.bc);
         chk(e.tag, "branch_address", {7'd0, branch_address}, {7'd0, e.ba});
         chk(e.tag, "reg_address",    reg_address,            e.ra);
         chk(e.tag, "id_instr",       id_instr,               e.instr);
         chk(e.tag, "reg_raddr",      {8'd0, reg_raddr},      {8'd0, e.raddr});
         chk(e.tag, "id_valid",       {9'd0, id_valid},       {9'd0, e.valid});
         chk(e.tag, "halted",         {9'd0, halted},         {9'd0, e.halted});
      end
   endtask

   // Drive one cycle of inputs, check the ID outputs, then advance past the edge
   task automatic step(input logic [9:0] ins, input logic stl, input exp_t e);
      instruction = ins;
      stall       = stl;
      sb.push_back(e);
      #2;
      check_out();
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t       e;
      logic [9:0] rnd_ins;
      logic       rnd_stl;

      for (int i = 0; i < 4; i++) rf[i] = 10'd0;
      reset       = 1'b1;
      instruction = NOP;
      stall       = 1'b0;
      #2;
      sb.push_back(base("reset", NOP, 1'b0));
      check_out();
      @(posedge clk);
      #1;
      reset = 1'b0;

      // NOP stream: valid rises one cycle after reset release
      step(NOP, 1'b0, base("nop0", NOP, 1'b0));
      step(NOP, 1'b0, base("nop1", NOP, 1'b1));
      step(J,   1'b0, base("nop2", NOP, 1'b1));

      // Stall outranks a pending jump, then the jump issues
      e = base("j_stall", J, 1'b1); e.pc = 2'b01; e.ja = 5'd0;
      step(ADD, 1'b1, e);
      e = base("j_go", J, 1'b1); e.pc = 2'b01;
      step(ADD, 1'b0, e);
      step(NOP, 1'b0, base("j_wrong_path", ADD, 1'b0));
      step(BEQZ, 1'b0, base("j_bubble", NOP, 1'b0));

      // Taken BEQZ (r1 = 0)
      e = base("beqz_taken", BEQZ, 1'b1); e.pc = 2'b11; e.bc = 10'd0;
      step(NOP, 1'b0, e);
      step(BEQZ, 1'b0, base("beqz_squash", NOP, 1'b0));
      step(NOP, 1'b0, base("beqz_bubble", BEQZ, 1'b0));
      step(BEQZ, 1'b0, base("beqz_nop", NOP, 1'b1));

      // Not-taken BEQZ (r1 = 7): no bubble follows
      rf[1] = 10'd7;
      e = base("beqz_not_taken", BEQZ, 1'b1); e.pc = 2'b11; e.bc = 10'd7;
      step(ADD, 1'b0, e);
      step(JR, 1'b0, base("add_after_beqz", ADD, 1'b1));

      // JR through r2 = 64, with a two-cycle stall during the bubble
      rf[2] = 10'd64;
      e = base("jr", JR, 1'b1); e.pc = 2'b10; e.ra = 10'd64;
      step(NOP, 1'b0, e);
      e = base("jr_stall0", NOP, 1'b0); e.pc = 2'b01; e.ja = 5'd0;
      step(ADD, 1'b1, e);
      e.tag = "jr_stall1";
      step(ADD, 1'b1, e);
      step(ADD, 1'b0, base("jr_squash", NOP, 1'b0));
      step(NOP, 1'b0, base("jr_bubble", ADD, 1'b0));
      step(HALT, 1'b0, base("pre_halt", NOP, 1'b1));
      step(ADD, 1'b0, base("halt_in_id", HALT, 1'b1));

      // Frozen in HALT regardless of instruction or stall
      for (int i = 0; i < 12; i++) begin
         rnd_ins = 10'($urandom);
         rnd_stl = 1'($urandom_range(0, 1));
         e = base("halted", ADD, 1'b0);
         e.pc = 2'b01; e.ja = 5'd0; e.halted = 1'b1;
         step(rnd_ins, rnd_stl, e);
      end

      // Asynchronous reset away from any clock edge clears HALT at once
      instruction = NOP;
      stall       = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      sb.push_back(base("async_reset", NOP, 1'b0));
      check_out();
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(NOP, 1'b0, base("post_reset0", NOP, 1'b0));
      step(NOP, 1'b0, base("post_reset1", NOP, 1'b1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
